multicycle_control: RTL and testbench

Sequencing controller for the multi-cycle RV32I core. It latches the fetched instruction, decodes it, and steps the shared ALU, register file, data memory and PC through FETCH/DECODE/EXECUTE/MEM/WB states. Memory accesses use a req/ready handshake. It drives the same control fields the single-cycle decoder produces, plus PC/IR enables and a retired-instruction counter.

---
 rtl/multicycle_control.sv | 104 ++++++++++
 tb/tb_multicycle_control.sv | 129 ++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXECUTE/MEM/WB sequencer for the multi-cycle RV32I core
// Ports: clk, reset (async, active-high); instr_rdata (fetched word), mem_ready (data
// memory handshake), btaken (branch compare result); ir_en/pc_en/pc_src/register_write_en/
// mem_req/mem_write_en strobes; imm_en/alu_control_en/rd_mux_en/*_type_data decoded from IR;
// state_o, instret (retired count), illegal_o (sticky illegal flag).
// Optional ILLEGAL_TRAP_EN: illegal instructions halt the core instead of acting as NOPs.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_rdata,
  input  logic        mem_ready,
  input  logic        btaken,
  output logic        ir_en,
  output logic        pc_en,
  output logic        pc_src,
  output logic        register_write_en,
  output logic        mem_req,
  output logic        mem_write_en,
  output logic        imm_en,
  output logic [3:0]  alu_control_en,
  output logic [1:0]  rd_mux_en,
  output logic [2:0]  S_type_data,
  output logic [2:0]  L_type_data,
  output logic [2:0]  B_type_data,
  output logic [2:0]  state_o,
  output logic [31:0] instret,
  output logic        illegal_o
);
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_S = 7'b0100011, OP_L = 7'b0000011, OP_B = 7'b1100011;
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5} state_t;
  state_t state_q, state_d;
  logic [31:0] ir_q, ir_d, instret_q, instret_d;
  logic illegal_q, illegal_d;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic ill, act, is_r, is_i, is_s, is_l, is_b, is_lui;
  logic unused_ir;
  assign unused_ir = ^{ir_q[24:15], ir_q[11:7]};
  always_comb begin
    op = ir_q[6:0];
    f3 = ir_q[14:12];
    f7 = ir_q[31:25];
    ill = !(op inside {OP_R, OP_I, OP_LUI, OP_S, OP_L, OP_B})
        | (op == OP_R && f7 != 7'b0000000 && f7 != 7'b0100000)
        | (op == OP_L && (f3 == 3'b011 || f3[2:1] == 2'b11))
        | (op == OP_S && f3 > 3'b010)
        | (op == OP_B && f3[2:1] == 2'b01);
    // illegal encodings decode to nothing, so they fall through EXECUTE as a NOP
    is_r = op == OP_R && !ill;
    is_i = op == OP_I;
    is_lui = op == OP_LUI;
    is_s = op == OP_S && !ill;
    is_l = op == OP_L && !ill;
    is_b = op == OP_B && !ill;
    act = state_q != FETCH && state_q != HALT;
    alu_control_en = !act ? 4'b0000 : is_r ? {ir_q[30], f3} : is_i ? {f3 == 3'b101 && ir_q[30], f3} : 4'b0000;
    imm_en = act && (is_i || is_s || is_l);
    rd_mux_en = !act ? 2'b00 : is_l ? 2'b01 : is_lui ? 2'b10 : 2'b00;
    S_type_data = act && is_s ? f3 : 3'b000;
    L_type_data = act && is_l ? f3 : 3'b000;
    B_type_data = act && is_b ? f3 : 3'b000;
    // gated by reset so every strobe reads 0 while reset is held
    ir_en = state_q == FETCH && !reset;
    mem_req = state_q == MEM;
    mem_write_en = state_q == MEM && is_s;
    register_write_en = state_q == WB;
    pc_src = state_q == EXECUTE && is_b && btaken;
    pc_en = state_q == WB || (state_q == EXECUTE && (is_b || ill)) || (state_q == MEM && is_s && mem_ready);
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE:  state_d = TRAP && ill ? HALT : EXECUTE;
      EXECUTE: state_d = is_r || is_i || is_lui ? WB : is_s || is_l ? MEM : FETCH;
      MEM:     state_d = !mem_ready ? MEM : is_s ? FETCH : WB;
      WB:      state_d = FETCH;
      default: state_d = HALT;
    endcase
    ir_d = ir_en ? instr_rdata : ir_q;
    instret_d = instret_q + {31'b0, pc_en};
    illegal_d = illegal_q || (TRAP && state_q == DECODE && ill);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      ir_q <= 32'h0000_0013;
      instret_q <= 32'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end
  assign state_o = state_q;
  assign instret = instret_q;
  assign illegal_o = illegal_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for multicycle_control with directed instruction vectors
module tb_multicycle_control;
  logic clk = 0, reset = 1, mem_ready = 0, btaken = 0;
  logic [31:0] instr_rdata = 0;
  logic ir_en, pc_en, pc_src, register_write_en, mem_req, mem_write_en, imm_en, illegal_o;
  logic [3:0] alu_control_en;
  logic [1:0] rd_mux_en;
  logic [2:0] S_type_data, L_type_data, B_type_data, state_o;
  logic [31:0] instret;
  multicycle_control dut (
    .clk(clk), .reset(reset), .instr_rdata(instr_rdata), .mem_ready(mem_ready), .btaken(btaken),
    .ir_en(ir_en), .pc_en(pc_en), .pc_src(pc_src), .register_write_en(register_write_en),
    .mem_req(mem_req), .mem_write_en(mem_write_en), .imm_en(imm_en), .alu_control_en(alu_control_en),
    .rd_mux_en(rd_mux_en), .S_type_data(S_type_data), .L_type_data(L_type_data), .B_type_data(B_type_data),
    .state_o(state_o), .instret(instret), .illegal_o(illegal_o)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [2:0] st;
    logic [6:0] sb;
    logic [3:0] alu;
    logic [1:0] rd;
    logic [2:0] s, l, b;
    logic ill;
    logic [31:0] ret;
  } exp_t;
  exp_t q[$];
  string nq[$];
  int checks = 0, fails = 0;
  logic [31:0] exp_ret = 0;
  logic exp_ill = 0;
  always @(negedge clk) begin
    exp_t e, a;
    string n;
    if (q.size() > 0) begin
      e = q.pop_front();
      n = nq.pop_front();
      a = {state_o, ir_en, pc_en, pc_src, register_write_en, mem_req, mem_write_en, imm_en,
           alu_control_en, rd_mux_en, S_type_data, L_type_data, B_type_data, illegal_o, instret};
      checks++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got %h want %h", n, a, e);
      end
    end
  end
  // sb = {ir_en, pc_en, pc_src, register_write_en, mem_req, mem_write_en, imm_en}
  task cyc(input string n, input logic r, input logic [31:0] ins, input logic rdy, input logic bt,
           input logic [2:0] st, input logic [6:0] sb, input logic [3:0] alu, input logic [1:0] rd,
           input logic [2:0] s, input logic [2:0] l, input logic [2:0] b);
    reset = r;
    instr_rdata = ins;
    mem_ready = rdy;
    btaken = bt;
    if (r) begin
      exp_ret = 0;
      exp_ill = 0;
    end
    q.push_back({st, sb, alu, rd, s, l, b, exp_ill, exp_ret});
    nq.push_back(n);
    @(posedge clk);
    #1;
    if (!r && sb[5]) exp_ret++;
  endtask
  task alu_op(input string n, input logic [31:0] ins, input logic imm, input logic [3:0] alu, input logic [1:0] rd);
    cyc({n, ".F"}, 0, ins, 1, 1, 0, 7'b1000000, 0, 0, 0, 0, 0);
    cyc({n, ".D"}, 0, 32'hFFFF_FFFF, 1, 1, 1, {6'b0, imm}, alu, rd, 0, 0, 0);
    cyc({n, ".E"}, 0, 32'hFFFF_FFFF, 1, 1, 2, {6'b0, imm}, alu, rd, 0, 0, 0);
    cyc({n, ".W"}, 0, 32'hFFFF_FFFF, 1, 1, 4, {6'b010100, imm}, alu, rd, 0, 0, 0);
  endtask
  task load(input string n, input logic [31:0] ins, input int waits, input logic [2:0] f3);
    cyc({n, ".F"}, 0, ins, 1, 1, 0, 7'b1000000, 0, 0, 0, 0, 0);
    cyc({n, ".D"}, 0, 0, 1, 1, 1, 7'b0000001, 0, 2'b01, 0, f3, 0);
    cyc({n, ".E"}, 0, 0, 1, 1, 2, 7'b0000001, 0, 2'b01, 0, f3, 0);
    for (int i = 0; i < waits; i++) cyc({n, ".Mw"}, 0, 0, 0, 1, 3, 7'b0000101, 0, 2'b01, 0, f3, 0);
    cyc({n, ".M"}, 0, 0, 1, 1, 3, 7'b0000101, 0, 2'b01, 0, f3, 0);
    cyc({n, ".W"}, 0, 0, 1, 1, 4, 7'b0101001, 0, 2'b01, 0, f3, 0);
  endtask
  task store(input string n, input logic [31:0] ins, input int waits, input logic [2:0] f3);
    cyc({n, ".F"}, 0, ins, 1, 1, 0, 7'b1000000, 0, 0, 0, 0, 0);
    cyc({n, ".D"}, 0, 0, 1, 1, 1, 7'b0000001, 0, 0, f3, 0, 0);
    cyc({n, ".E"}, 0, 0, 1, 1, 2, 7'b0000001, 0, 0, f3, 0, 0);
    for (int i = 0; i < waits; i++) cyc({n, ".Mw"}, 0, 0, 0, 1, 3, 7'b0000111, 0, 0, f3, 0, 0);
    cyc({n, ".M"}, 0, 0, 1, 1, 3, 7'b0100111, 0, 0, f3, 0, 0);
  endtask
  task branch(input string n, input logic [31:0] ins, input logic bt, input logic [2:0] f3);
    cyc({n, ".F"}, 0, ins, 1, !bt, 0, 7'b1000000, 0, 0, 0, 0, 0);
    cyc({n, ".D"}, 0, 0, 1, !bt, 1, 7'b0000000, 0, 0, 0, 0, f3);
    cyc({n, ".E"}, 0, 0, 1, bt, 2, {1'b0, 1'b1, bt, 4'b0}, 0, 0, 0, 0, f3);
  endtask
  initial begin
    @(posedge clk);
    #1;
    cyc("reset", 1, 0, 1, 1, 0, 7'b0, 0, 0, 0, 0, 0);
    alu_op("add", 32'h0020_81B3, 0, 4'b0000, 2'b00);
    alu_op("srai", 32'h4032_D293, 1, 4'b1101, 2'b00);
    alu_op("addi", 32'hFFF0_0093, 1, 4'b0000, 2'b00);
    alu_op("sub", 32'h4031_00B3, 0, 4'b1000, 2'b00);
    alu_op("lui", 32'h1234_52B7, 0, 4'b0000, 2'b10);
    load("lw", 32'h0000_A203, 2, 3'b010);
    store("sw", 32'h0020_A023, 0, 3'b010);
    branch("beq", 32'h0020_8463, 1, 3'b000);
    branch("bne", 32'h0020_9463, 0, 3'b001);
    cyc("swr.F", 0, 32'h0020_A023, 1, 1, 0, 7'b1000000, 0, 0, 0, 0, 0);
    cyc("swr.D", 0, 0, 1, 1, 1, 7'b0000001, 0, 0, 3'b010, 0, 0);
    cyc("swr.E", 0, 0, 1, 1, 2, 7'b0000001, 0, 0, 3'b010, 0, 0);
    cyc("swr.M", 0, 0, 0, 1, 3, 7'b0000111, 0, 0, 3'b010, 0, 0);
    cyc("swr.rst", 1, 0, 1, 1, 0, 7'b0000000, 0, 0, 0, 0, 0);
    alu_op("add2", 32'h0020_81B3, 0, 4'b0000, 2'b00);
    cyc("ill.F", 0, 32'h0000_007F, 1, 1, 0, 7'b1000000, 0, 0, 0, 0, 0);
    cyc("ill.D", 0, 0, 1, 1, 1, 7'b0000000, 0, 0, 0, 0, 0);
`ifdef ILLEGAL_TRAP_EN
    exp_ill = 1;
    for (int i = 0; i < 10; i++) cyc("ill.H", 0, 32'h0020_81B3, 1, 1, 5, 7'b0000000, 0, 0, 0, 0, 0);
`else
    cyc("ill.E", 0, 0, 1, 1, 2, 7'b0100000, 0, 0, 0, 0, 0);
    alu_op("add3", 32'h0020_81B3, 0, 4'b0000, 2'b00);
`endif
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
